// File: rtl/lr_pkg.sv
// Shared types and constants for the linear-regression SGD training sequencer.
package lr_pkg;

    localparam int DEF_NUM_SAMPLES  = 4;
    localparam int DEF_NUM_FEATURES = 4;
    localparam int DEF_MULT_LAT     = 1;
    localparam int DEF_EPOCH_W      = 16;

    // Arithmetic shift applied by the datapath error stage to form the SGD step.
    localparam int STEP_SHIFT = 7;

    // Wide enough for a multiplier latency of up to 7 cycles.
    localparam int WAIT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_FWD_WAIT,
        ST_ERR,
        ST_UPD,
        ST_UPD_WAIT,
        ST_WB,
        ST_FIN
    } lr_seq_state_t;

    // Value loaded into the wait counter so a wait state lasts exactly multLat cycles.
    function automatic logic [WAIT_W-1:0] waitLoadValue(input int multLat);
        if (multLat <= 0) begin
            return '0;
        end
        return WAIT_W'(multLat - 1);
    endfunction

endpackage

// File: rtl/lr_wait_cnt.sv
// Loadable down-counter used to hold the sequencer while the multipliers settle.
module lr_wait_cnt
    import lr_pkg::*;
(
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] loadVal_i,
    input  logic              dec_i,
    output logic              expired_o
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Load takes priority; decrementing stops at zero so expired stays asserted.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WAIT_W'(1);
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/lr_train_sequencer.sv
// Control FSM that walks the 4-feature SGD datapath through samples and epochs,
// issuing one-cycle enables for forward multiply, error, gradient multiply and write-back.
module lr_train_sequencer
    import lr_pkg::*;
#(
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int MULT_LAT     = DEF_MULT_LAT,
    parameter int EPOCH_W      = DEF_EPOCH_W,
    localparam int SIDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int BASE_W = ((NUM_SAMPLES * NUM_FEATURES) > 1) ?
                            $clog2(NUM_SAMPLES * NUM_FEATURES) : 1
)(
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic               busy,
    output logic               done,
    output logic [SIDX_W-1:0]  sample_idx,
    output logic [BASE_W-1:0]  dp_base,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               fwd_en,
    output logic               err_en,
    output logic               upd_en,
    output logic               wt_we
);

    localparam logic [SIDX_W-1:0] LAST_SAMPLE = SIDX_W'(NUM_SAMPLES - 1);
    localparam logic [BASE_W-1:0] BASE_STEP   = BASE_W'(NUM_FEATURES);
    localparam logic [WAIT_W-1:0] WAIT_LOAD   = waitLoadValue(MULT_LAT);
    localparam bit                HAS_WAIT    = (MULT_LAT > 0);

    lr_seq_state_t      state_q, state_d;
    logic [SIDX_W-1:0]  sampleIdx_q, sampleIdx_d;
    logic [BASE_W-1:0]  dpBase_q, dpBase_d;
    logic [EPOCH_W-1:0] epochCnt_q, epochCnt_d;
    logic [EPOCH_W-1:0] epochs_q, epochs_d;
    logic [EPOCH_W:0]   epochNext;
    logic               waitLoad;
    logic               waitDec;
    logic               waitExpired;

    lr_wait_cnt u_wait (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .load_i    (waitLoad),
        .loadVal_i (WAIT_LOAD),
        .dec_i     (waitDec),
        .expired_o (waitExpired)
    );

    // One extra bit lets the last-epoch compare and saturation see the carry.
    assign epochNext = {1'b0, epochCnt_q} + {{EPOCH_W{1'b0}}, 1'b1};

    // Next-state and counter update; abort overrides only the next state from any busy state.
    always_comb begin
        state_d     = state_q;
        sampleIdx_d = sampleIdx_q;
        dpBase_d    = dpBase_q;
        epochCnt_d  = epochCnt_q;
        epochs_d    = epochs_q;
        waitLoad    = 1'b0;
        waitDec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    epochs_d    = num_epochs;
                    sampleIdx_d = '0;
                    dpBase_d    = '0;
                    epochCnt_d  = '0;
                    state_d     = (num_epochs != '0) ? ST_FWD : ST_FIN;
                end
            end
            ST_FWD: begin
                waitLoad = 1'b1;
                state_d  = HAS_WAIT ? ST_FWD_WAIT : ST_ERR;
            end
            ST_FWD_WAIT: begin
                waitDec = 1'b1;
                if (waitExpired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                state_d = ST_UPD;
            end
            ST_UPD: begin
                waitLoad = 1'b1;
                state_d  = HAS_WAIT ? ST_UPD_WAIT : ST_WB;
            end
            ST_UPD_WAIT: begin
                waitDec = 1'b1;
                if (waitExpired) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (!abort) begin
                    if (sampleIdx_q != LAST_SAMPLE) begin
                        sampleIdx_d = sampleIdx_q + SIDX_W'(1);
                        dpBase_d    = dpBase_q + BASE_STEP;
                        state_d     = ST_FWD;
                    end else begin
                        sampleIdx_d = '0;
                        dpBase_d    = '0;
                        epochCnt_d  = epochNext[EPOCH_W] ? epochCnt_q : epochNext[EPOCH_W-1:0];
                        state_d     = (epochNext == {1'b0, epochs_q}) ? ST_FIN : ST_FWD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // State and bookkeeping registers, all returning to idle values on reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sampleIdx_q <= '0;
            dpBase_q    <= '0;
            epochCnt_q  <= '0;
            epochs_q    <= '0;
        end else begin
            state_q     <= state_d;
            sampleIdx_q <= sampleIdx_d;
            dpBase_q    <= dpBase_d;
            epochCnt_q  <= epochCnt_d;
            epochs_q    <= epochs_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign fwd_en     = (state_q == ST_FWD);
    assign err_en     = (state_q == ST_ERR);
    assign upd_en     = (state_q == ST_UPD);
    assign wt_we      = (state_q == ST_WB);
    assign sample_idx = sampleIdx_q;
    assign dp_base    = dpBase_q;
    assign epoch_cnt  = epochCnt_q;

endmodule

// File: tb/tb_lr_train_sequencer.sv
// Self-checking bench: two sequencers (multiplier latency 1 and 0) driven by the same
// stimulus and compared every cycle against a cycle-position model of a training run.
module tb_lr_train_sequencer;

    localparam int NS = 4;
    localparam int NF = 4;
    localparam int EW = 16;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [EW-1:0] numEpochs = '0;

    logic          busyA, doneA, fwdA, errA, updA, weA;
    logic [1:0]    sidxA;
    logic [3:0]    baseA;
    logic [EW-1:0] epA;
    logic          busyB, doneB, fwdB, errB, updB, weB;
    logic [1:0]    sidxB;
    logic [3:0]    baseB;
    logic [EW-1:0] epB;

    int  errors = 0;
    int  checks = 0;
    bit  checkEn = 1'b0;

    always #5 CLK = ~CLK;

    lr_train_sequencer #(.NUM_SAMPLES(NS), .NUM_FEATURES(NF), .MULT_LAT(1), .EPOCH_W(EW)) dutA (
        .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort), .num_epochs(numEpochs),
        .busy(busyA), .done(doneA), .sample_idx(sidxA), .dp_base(baseA), .epoch_cnt(epA),
        .fwd_en(fwdA), .err_en(errA), .upd_en(updA), .wt_we(weA)
    );

    lr_train_sequencer #(.NUM_SAMPLES(NS), .NUM_FEATURES(NF), .MULT_LAT(0), .EPOCH_W(EW)) dutB (
        .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort), .num_epochs(numEpochs),
        .busy(busyB), .done(doneB), .sample_idx(sidxB), .dp_base(baseB), .epoch_cnt(epB),
        .fwd_en(fwdB), .err_en(errB), .upd_en(updB), .wt_we(weB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       busy;
        bit       done;
        bit [3:0] en;
        int       sidx;
        int       ep;
    } exp_t;

    // Model state per instance: running flag, cycle number within run, latched epochs, held values.
    bit mBusy[2];
    int mC[2];
    int mE[2];
    int mHoldS[2];
    int mHoldE[2];

    function automatic int mlOf(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int runLength(input int e, input int ml);
        return (e == 0) ? 1 : e * NS * (4 + 2 * ml) + 1;
    endfunction

    function automatic exp_t predict(input int i);
        exp_t r;
        int   ml;
        int   p;
        int   len;
        int   k;
        int   pos;
        ml     = mlOf(i);
        p      = 4 + 2 * ml;
        len    = runLength(mE[i], ml);
        r.busy = 1'b0;
        r.done = 1'b0;
        r.en   = 4'b0;
        r.sidx = mHoldS[i];
        r.ep   = mHoldE[i];
        if (mBusy[i]) begin
            r.busy = 1'b1;
            if (mC[i] == len) begin
                r.done = 1'b1;
                r.sidx = 0;
                r.ep   = mE[i];
            end else begin
                k      = mC[i] - 1;
                pos    = k % p;
                r.sidx = (k / p) % NS;
                r.ep   = k / (p * NS);
                r.en[3] = (pos == 0);
                r.en[2] = (pos == 1 + ml);
                r.en[1] = (pos == 2 + ml);
                r.en[0] = (pos == p - 1);
            end
        end
        return r;
    endfunction

    // Advance the run model on each clock edge; reset returns it to idle immediately.
    always @(posedge CLK or negedge rst_n) begin
        exp_t cur;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mBusy[i] = 1'b0; mC[i] = 0; mE[i] = 0; mHoldS[i] = 0; mHoldE[i] = 0;
            end else if (!mBusy[i]) begin
                if (start && !abort) begin
                    mBusy[i] = 1'b1; mC[i] = 1; mE[i] = int'(numEpochs);
                end
            end else begin
                cur = predict(i);
                if (abort || (mC[i] == runLength(mE[i], mlOf(i)))) begin
                    mBusy[i] = 1'b0; mHoldS[i] = cur.sidx; mHoldE[i] = cur.ep;
                end else begin
                    mC[i]++;
                end
            end
        end
    end

    // Compare both instances against the model in the middle of every cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (checkEn) begin
            for (int i = 0; i < 2; i++) begin
                e = predict(i);
                if (i == 0) begin
                    checkOutput("busyA", 32'(busyA), 32'(e.busy));
                    checkOutput("doneA", 32'(doneA), 32'(e.done));
                    checkOutput("enA", 32'({fwdA, errA, updA, weA}), 32'(e.en));
                    checkOutput("sidxA", 32'(sidxA), 32'(e.sidx));
                    checkOutput("baseA", 32'(baseA), 32'(e.sidx * NF));
                    checkOutput("epochA", 32'(epA), 32'(e.ep));
                end else begin
                    checkOutput("busyB", 32'(busyB), 32'(e.busy));
                    checkOutput("doneB", 32'(doneB), 32'(e.done));
                    checkOutput("enB", 32'({fwdB, errB, updB, weB}), 32'(e.en));
                    checkOutput("sidxB", 32'(sidxB), 32'(e.sidx));
                    checkOutput("baseB", 32'(baseB), 32'(e.sidx * NF));
                    checkOutput("epochB", 32'(epB), 32'(e.ep));
                end
            end
        end
    end

    // Start a run, optionally poke start mid-run, and measure completion of both instances.
    task automatic applyStimulus(input int epochs, input int pokeAt, input int maxCyc,
                                 output int doneAAt, output int doneBAt,
                                 output int wraps, output int enCount);
        logic [1:0] prevS;
        doneAAt = -1; doneBAt = -1; wraps = 0; enCount = 0;
        @(negedge CLK);
        start     = 1'b1;
        numEpochs = EW'(epochs);
        @(negedge CLK);
        start = 1'b0;
        prevS = 2'd0;
        for (int n = 1; n <= maxCyc; n++) begin
            if (n > 1) @(negedge CLK);
            start = 1'b0;
            if (n == pokeAt) begin
                start     = 1'b1;
                numEpochs = EW'(7);
            end
            enCount += int'(fwdA) + int'(errA) + int'(updA) + int'(weA)
                     + int'(fwdB) + int'(errB) + int'(updB) + int'(weB);
            if (prevS == 2'd3 && sidxA == 2'd0) wraps++;
            prevS = sidxA;
            if (doneB && doneBAt < 0) doneBAt = n;
            if (doneA) begin
                doneAAt = n;
                break;
            end
        end
        start = 1'b0;
        if (doneAAt < 0) checkOutput("doneTimeout", 32'(0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dA, dB, wr, en;

        @(negedge CLK);
        checkEn = 1'b1;
        checkOutput("resetBusy", 32'(busyA), 32'(0));
        checkOutput("resetEn", 32'({fwdA, errA, updA, weA, doneA}), 32'(0));
        checkOutput("resetIdx", 32'({sidxA, baseA, epA}), 32'(0));
        rst_n = 1'b1;
        @(negedge CLK);

        $display("[TB] single epoch");
        applyStimulus(1, 0, 200, dA, dB, wr, en);
        checkOutput("e1DoneA", 32'(dA), 32'(25));
        checkOutput("e1DoneB", 32'(dB), 32'(17));
        checkOutput("e1EpochA", 32'(epA), 32'(1));

        $display("[TB] three epochs back to back");
        applyStimulus(3, 0, 400, dA, dB, wr, en);
        checkOutput("e3DoneA", 32'(dA), 32'(73));
        checkOutput("e3DoneB", 32'(dB), 32'(49));
        checkOutput("e3Wraps", 32'(wr), 32'(3));
        checkOutput("e3EpochA", 32'(epA), 32'(3));

        $display("[TB] zero epochs");
        applyStimulus(0, 0, 20, dA, dB, wr, en);
        checkOutput("e0DoneA", 32'(dA), 32'(1));
        checkOutput("e0DoneB", 32'(dB), 32'(1));
        checkOutput("e0Enables", 32'(en), 32'(0));
        @(negedge CLK);
        checkOutput("e0BusyAfter", 32'({busyA, busyB}), 32'(0));

        $display("[TB] abort in UPD_WAIT of sample 2");
        @(negedge CLK);
        start = 1'b1; numEpochs = EW'(1);
        @(negedge CLK);
        start = 1'b0;
        repeat (16) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checkOutput("abBusy", 32'(busyA), 32'(0));
        checkOutput("abDone", 32'(doneA), 32'(0));
        checkOutput("abSidx", 32'(sidxA), 32'(2));
        checkOutput("abEpoch", 32'(epA), 32'(0));
        applyStimulus(1, 0, 200, dA, dB, wr, en);
        checkOutput("abRestartDone", 32'(dA), 32'(25));

        $display("[TB] start while busy is ignored");
        applyStimulus(1, 5, 200, dA, dB, wr, en);
        checkOutput("pokeDoneA", 32'(dA), 32'(25));
        checkOutput("pokeEpochA", 32'(epA), 32'(1));

        $display("[TB] start with abort in idle");
        @(negedge CLK);
        start = 1'b1; abort = 1'b1; numEpochs = EW'(1);
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        checkOutput("saBusy", 32'({busyA, busyB}), 32'(0));

        $display("[TB] async reset during ERR of sample 1");
        @(negedge CLK);
        start = 1'b1; numEpochs = EW'(1);
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        checkOutput("rsErrBefore", 32'({errA, sidxA}), 32'({1'b1, 2'd1}));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rsOutsA", 32'({busyA, doneA, fwdA, errA, updA, weA, sidxA, baseA}), 32'(0));
        checkOutput("rsEpochA", 32'(epA), 32'(0));
        checkOutput("rsOutsB", 32'({busyB, doneB, fwdB, errB, updB, weB, sidxB, baseB}), 32'(0));
        @(negedge CLK);
        rst_n = 1'b1;
        applyStimulus(1, 0, 200, dA, dB, wr, en);
        checkOutput("rsAfterDone", 32'(dA), 32'(25));

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
